// File: rtl/seg7_scan_monitor.sv
// Receive-side monitor for a multiplexed two-digit 7-segment display: filters and decodes
// each scanned glyph, reassembles the count and checks it against a fixed 10-entry sequence.
module seg7_scan_monitor #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [3:0]       control_i,
    input  logic [7:0]       display_i,
    output logic [7:0]       value_o,
    output logic             value_valid_o,
    output logic             locked_o,
    output logic [3:0]       seq_index_o,
    output logic             seq_error_o,
    output logic             glyph_error_o,
    output logic [ERR_W-1:0] err_count_o
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    // Entry 0 sits in the low byte: 120,154,204,254,15,61,55,50,86,147.
    localparam logic [79:0] SeqTable = {8'h93, 8'h56, 8'h32, 8'h37, 8'h3D,
                                        8'h0F, 8'hFE, 8'hCC, 8'h9A, 8'h78};

    typedef enum logic [0:0] {StHunt, StLocked} state_e;

    logic [3:0]       ctrl_q;
    logic [7:0]       disp_q;
    logic [11:0]      prev_q;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             same;
    logic             acc_q, acc_d;
    logic [3:0]       acc_ctrl_q;
    logic [6:0]       acc_seg_q;

    logic             glyph_ok;
    logic [3:0]       glyph_nib;
    logic             is_hi, is_lo;
    logic [3:0]       hi_nib_q, hi_nib_d, lo_nib_q, lo_nib_d;
    logic             hi_seen_q, hi_seen_d, lo_seen_q, lo_seen_d;
    logic             first_q, first_d;
    logic [7:0]       value_q, value_d;
    logic             vv_q, vv_d;
    logic             glyph_err_q, glyph_err_d;

    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic             seq_err_q, seq_err_d;
    logic             found;
    logic [3:0]       found_idx;
    logic [3:0]       next_idx;
    logic [7:0]       expected;

    logic [ERR_W-1:0] err_q, err_d;
    logic [ERR_W:0]   err_sum;

    // Stability filter: the count parks at STABLE_CYCLES so a held pattern is accepted once.
    always_comb begin
        same  = ({ctrl_q, disp_q} == prev_q);
        cnt_d = cnt_q;
        acc_d = 1'b0;
        if (!same) begin
            cnt_d = CntW'(1);
        end else if (cnt_q < CntW'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + CntW'(1);
            acc_d = (cnt_q == CntW'(STABLE_CYCLES - 1));
        end
    end

    // Decimal point is don't-care for decoding.
    always_comb begin
        glyph_ok  = 1'b1;
        glyph_nib = 4'h0;
        case ({acc_seg_q, 1'b0})
            8'hFC: glyph_nib = 4'h0;
            8'h60: glyph_nib = 4'h1;
            8'hDA: glyph_nib = 4'h2;
            8'hF2: glyph_nib = 4'h3;
            8'h66: glyph_nib = 4'h4;
            8'hB6: glyph_nib = 4'h5;
            8'hBE: glyph_nib = 4'h6;
            8'hE0: glyph_nib = 4'h7;
            8'hFE: glyph_nib = 4'h8;
            8'hF6: glyph_nib = 4'h9;
            8'hFA: glyph_nib = 4'hA;
            8'h3E: glyph_nib = 4'hB;
            8'h1A: glyph_nib = 4'hC;
            8'h7A: glyph_nib = 4'hD;
            8'hDE: glyph_nib = 4'hE;
            8'h8E: glyph_nib = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
    end

    always_comb begin
        is_hi       = acc_q && (acc_ctrl_q == 4'b0111);
        is_lo       = acc_q && (acc_ctrl_q == 4'b1011);
        hi_nib_d    = hi_nib_q;
        lo_nib_d    = lo_nib_q;
        hi_seen_d   = hi_seen_q;
        lo_seen_d   = lo_seen_q;
        glyph_err_d = 1'b0;
        value_d     = value_q;
        vv_d        = 1'b0;
        first_d     = first_q;
        if ((is_hi || is_lo) && !glyph_ok) begin
            glyph_err_d = 1'b1;
        end else if (is_hi) begin
            hi_nib_d  = glyph_nib;
            hi_seen_d = 1'b1;
        end else if (is_lo) begin
            lo_nib_d  = glyph_nib;
            lo_seen_d = 1'b1;
        end
        // Frame completes on the acceptance that fills the second slot.
        if (hi_seen_d && lo_seen_d) begin
            hi_seen_d = 1'b0;
            lo_seen_d = 1'b0;
            if (({hi_nib_d, lo_nib_d} != value_q) || first_q) begin
                value_d = {hi_nib_d, lo_nib_d};
                vv_d    = 1'b1;
                first_d = 1'b0;
            end
        end
    end

    always_comb begin
        found     = 1'b0;
        found_idx = 4'd0;
        expected  = 8'h00;
        next_idx  = (idx_q == 4'd9) ? 4'd0 : idx_q + 4'd1;
        for (int i = 0; i < 10; i++) begin
            if (value_q == SeqTable[i*8 +: 8]) begin
                found     = 1'b1;
                found_idx = 4'(i);
            end
            if (next_idx == 4'(i)) begin
                expected = SeqTable[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        seq_err_d = 1'b0;
        if (vv_q) begin
            unique case (state_q)
                StHunt: begin
                    if (found) begin
                        state_d = StLocked;
                        idx_d   = found_idx;
                    end
                end
                StLocked: begin
                    if (value_q == expected) begin
                        idx_d = next_idx;
                    end else if (found) begin
                        seq_err_d = 1'b1;
                        idx_d     = found_idx;
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = StHunt;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_comb begin
        err_sum = {1'b0, err_q} + {{ERR_W{1'b0}}, seq_err_d} + {{ERR_W{1'b0}}, glyph_err_d};
        err_d   = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ctrl_q      <= 4'hF;
            disp_q      <= 8'h00;
            prev_q      <= {4'hF, 8'h00};
            cnt_q       <= '0;
            acc_q       <= 1'b0;
            acc_ctrl_q  <= 4'hF;
            acc_seg_q   <= 7'h00;
            hi_nib_q    <= 4'h0;
            lo_nib_q    <= 4'h0;
            hi_seen_q   <= 1'b0;
            lo_seen_q   <= 1'b0;
            first_q     <= 1'b1;
            value_q     <= 8'h00;
            vv_q        <= 1'b0;
            glyph_err_q <= 1'b0;
            state_q     <= StHunt;
            idx_q       <= 4'd0;
            seq_err_q   <= 1'b0;
            err_q       <= '0;
        end else begin
            ctrl_q      <= control_i;
            disp_q      <= display_i;
            prev_q      <= {ctrl_q, disp_q};
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            acc_ctrl_q  <= ctrl_q;
            acc_seg_q   <= disp_q[7:1];
            hi_nib_q    <= hi_nib_d;
            lo_nib_q    <= lo_nib_d;
            hi_seen_q   <= hi_seen_d;
            lo_seen_q   <= lo_seen_d;
            first_q     <= first_d;
            value_q     <= value_d;
            vv_q        <= vv_d;
            glyph_err_q <= glyph_err_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            seq_err_q   <= seq_err_d;
            err_q       <= err_d;
        end
    end

    assign value_o       = value_q;
    assign value_valid_o = vv_q;
    assign locked_o      = (state_q == StLocked);
    assign seq_index_o   = idx_q;
    assign seq_error_o   = seq_err_q;
    assign glyph_error_o = glyph_err_q;
    assign err_count_o   = err_q;

endmodule

// File: tb/tb_seg7_scan_monitor.sv
// Directed bench for seg7_scan_monitor: scans digits onto the pins and checks decoded
// value, sequence tracking, error pulses and the saturating error counter.
module tb_seg7_scan_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] control;
    logic [7:0] display;
    logic [7:0] value_o;
    logic       value_valid_o;
    logic       locked_o;
    logic [3:0] seq_index_o;
    logic       seq_error_o;
    logic       glyph_error_o;
    logic [7:0] err_count_o;

    int n_vec  = 0;
    int n_fail = 0;
    int n_vv   = 0;
    int n_se   = 0;
    int n_ge   = 0;

    always #5 clk = ~clk;

    seg7_scan_monitor #(
        .STABLE_CYCLES(4),
        .ERR_W        (8)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .control_i    (control),
        .display_i    (display),
        .value_o      (value_o),
        .value_valid_o(value_valid_o),
        .locked_o     (locked_o),
        .seq_index_o  (seq_index_o),
        .seq_error_o  (seq_error_o),
        .glyph_error_o(glyph_error_o),
        .err_count_o  (err_count_o)
    );

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (value_valid_o) n_vv++;
        if (seq_error_o) n_se++;
        if (glyph_error_o) n_ge++;
    end

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 8'hFC;  4'h1: seg_of = 8'h60;  4'h2: seg_of = 8'hDA;
            4'h3: seg_of = 8'hF2;  4'h4: seg_of = 8'h66;  4'h5: seg_of = 8'hB6;
            4'h6: seg_of = 8'hBE;  4'h7: seg_of = 8'hE0;  4'h8: seg_of = 8'hFE;
            4'h9: seg_of = 8'hF6;  4'hA: seg_of = 8'hFA;  4'hB: seg_of = 8'h3E;
            4'hC: seg_of = 8'h1A;  4'hD: seg_of = 8'h7A;  4'hE: seg_of = 8'hDE;
            default: seg_of = 8'h8E;
        endcase
    endfunction

    task automatic do_reset();
        reset   = 1'b1;
        control = 4'hF;
        display = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] c, input logic [7:0] s, input int n);
        control = c;
        display = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_value(input logic [7:0] v, input int n);
        send_digit(4'b0111, seg_of(v[7:4]), n);
        send_digit(4'b1011, seg_of(v[3:0]), n);
    endtask

    task automatic test_reset();
        int vv0;
        do_reset();
        n_vec++; if (value_o !== 8'h00) begin n_fail++;
            $display("FAIL rst_value: got %0h want 00", value_o); end
        n_vec++; if (value_valid_o !== 1'b0) begin n_fail++;
            $display("FAIL rst_vv: got %0b want 0", value_valid_o); end
        n_vec++; if (locked_o !== 1'b0) begin n_fail++;
            $display("FAIL rst_locked: got %0b want 0", locked_o); end
        n_vec++; if (seq_index_o !== 4'd0) begin n_fail++;
            $display("FAIL rst_index: got %0d want 0", seq_index_o); end
        n_vec++; if (err_count_o !== 8'h00) begin n_fail++;
            $display("FAIL rst_err: got %0h want 00", err_count_o); end
        n_vec++; if ({seq_error_o, glyph_error_o} !== 2'b00) begin n_fail++;
            $display("FAIL rst_pulses: got %b want 00", {seq_error_o, glyph_error_o}); end
        // First frame after reset is reported even though it equals the reset value.
        vv0 = n_vv;
        send_value(8'h00, 8);
        n_vec++; if (n_vv - vv0 !== 1) begin n_fail++;
            $display("FAIL first_frame_vv: got %0d want 1", n_vv - vv0); end
        n_vec++; if (locked_o !== 1'b0) begin n_fail++;
            $display("FAIL first_frame_hunt: got %0b want 0", locked_o); end
    endtask

    task automatic test_basic();
        int lat;
        int vv0;
        do_reset();
        vv0 = n_vv;
        lat = 0;
        send_digit(4'b0111, 8'hE0, 8);
        control = 4'b1011;
        display = 8'hFE;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (value_valid_o && lat == 0) lat = i;
        end
        n_vec++; if (lat !== 6) begin n_fail++;
            $display("FAIL latency: got %0d want 6", lat); end
        n_vec++; if (value_o !== 8'h78) begin n_fail++;
            $display("FAIL basic_value: got %0h want 78", value_o); end
        n_vec++; if (n_vv - vv0 !== 1) begin n_fail++;
            $display("FAIL basic_vv: got %0d want 1", n_vv - vv0); end
        n_vec++; if ({locked_o, seq_index_o} !== {1'b1, 4'd0}) begin n_fail++;
            $display("FAIL basic_lock: got %b/%0d want 1/0", locked_o, seq_index_o); end
    endtask

    task automatic test_full_cycle();
        logic [7:0] seq [10];
        int vv0;
        int se0;
        seq = '{8'h9A, 8'hCC, 8'hFE, 8'h0F, 8'h3D, 8'h37, 8'h32, 8'h56, 8'h93, 8'h78};
        vv0 = n_vv;
        se0 = n_se;
        for (int k = 0; k < 10; k++) begin
            send_value(seq[k], 8);
            send_value(seq[k], 8);
            n_vec++; if ({value_o, seq_index_o} !== {seq[k], 4'((k + 1) % 10)}) begin n_fail++;
                $display("FAIL cycle_step%0d: got %0h/%0d want %0h/%0d", k, value_o,
                         seq_index_o, seq[k], (k + 1) % 10); end
        end
        n_vec++; if (n_vv - vv0 !== 10) begin n_fail++;
            $display("FAIL cycle_vv: got %0d want 10", n_vv - vv0); end
        n_vec++; if (n_se - se0 !== 0) begin n_fail++;
            $display("FAIL cycle_seqerr: got %0d want 0", n_se - se0); end
        n_vec++; if (locked_o !== 1'b1) begin n_fail++;
            $display("FAIL cycle_locked: got %0b want 1", locked_o); end
    endtask

    task automatic test_inject();
        int se0;
        do_reset();
        send_value(8'h78, 8);
        send_value(8'h9A, 8);
        send_value(8'hCC, 8);
        se0 = n_se;
        send_value(8'h55, 8);
        n_vec++; if (n_se - se0 !== 1) begin n_fail++;
            $display("FAIL inject_seqerr: got %0d want 1", n_se - se0); end
        n_vec++; if (locked_o !== 1'b0) begin n_fail++;
            $display("FAIL inject_unlock: got %0b want 0", locked_o); end
        n_vec++; if (err_count_o !== 8'd1) begin n_fail++;
            $display("FAIL inject_err: got %0d want 1", err_count_o); end
        send_value(8'h0F, 8);
        n_vec++; if ({locked_o, seq_index_o} !== {1'b1, 4'd4}) begin n_fail++;
            $display("FAIL relock: got %b/%0d want 1/4", locked_o, seq_index_o); end
        n_vec++; if (err_count_o !== 8'd1) begin n_fail++;
            $display("FAIL relock_err: got %0d want 1", err_count_o); end
    endtask

    task automatic test_glyph_error();
        int ge0;
        int vv0;
        do_reset();
        ge0 = n_ge;
        vv0 = n_vv;
        send_digit(4'b0111, 8'h00, 8);
        n_vec++; if (n_ge - ge0 !== 1) begin n_fail++;
            $display("FAIL glyph_pulse: got %0d want 1", n_ge - ge0); end
        n_vec++; if (err_count_o !== 8'd1) begin n_fail++;
            $display("FAIL glyph_err: got %0d want 1", err_count_o); end
        n_vec++; if ({value_o, 8'(n_vv - vv0)} !== {8'h00, 8'd0}) begin n_fail++;
            $display("FAIL glyph_value: got %0h/%0d want 00/0", value_o, n_vv - vv0); end
    endtask

    task automatic test_filter();
        int vv0;
        int ge0;
        do_reset();
        send_value(8'h78, 8);
        vv0 = n_vv;
        ge0 = n_ge;
        for (int i = 0; i < 6; i++) begin
            send_digit(4'b0111, (i % 2 == 0) ? 8'hFC : 8'h60, 3);
        end
        send_digit(4'b1111, 8'hFC, 8);
        n_vec++; if ({8'(n_vv - vv0), 8'(n_ge - ge0)} !== 16'h0000) begin n_fail++;
            $display("FAIL filter_pulses: got vv %0d ge %0d want 0 0", n_vv - vv0, n_ge - ge0); end
        send_digit(4'b1011, seg_of(4'h5), 8);
        n_vec++; if ({value_o, 8'(n_vv - vv0)} !== {8'h78, 8'd0}) begin n_fail++;
            $display("FAIL filter_no_hi: got %0h/%0d want 78/0", value_o, n_vv - vv0); end
        send_digit(4'b0111, seg_of(4'h7), 8);
        n_vec++; if ({value_o, 8'(n_vv - vv0)} !== {8'h75, 8'd1}) begin n_fail++;
            $display("FAIL filter_frame: got %0h/%0d want 75/1", value_o, n_vv - vv0); end
    endtask

    task automatic test_saturate_and_reset();
        int se0;
        int vv0;
        do_reset();
        se0 = n_se;
        for (int f = 0; f < 260; f++) begin
            send_value((f % 2 == 1) ? 8'hCC : 8'h78, 6);
            if (f == 100) begin
                repeat (2) @(posedge clk);
                #1;
                n_vec++; if (err_count_o !== 8'd100) begin n_fail++;
                    $display("FAIL err_count_mid: got %0d want 100", err_count_o); end
            end
        end
        repeat (4) @(posedge clk);
        #1;
        n_vec++; if (err_count_o !== 8'hFF) begin n_fail++;
            $display("FAIL err_saturate: got %0h want ff", err_count_o); end
        n_vec++; if (n_se - se0 !== 259) begin n_fail++;
            $display("FAIL seqerr_count: got %0d want 259", n_se - se0); end
        send_digit(4'b0111, seg_of(4'h1), 8);
        do_reset();
        n_vec++; if ({value_o, value_valid_o, locked_o, seq_index_o} !== 14'h0) begin n_fail++;
            $display("FAIL midrst_state: got %0h/%b/%b/%0d want 0/0/0/0", value_o,
                     value_valid_o, locked_o, seq_index_o); end
        n_vec++; if ({err_count_o, seq_error_o, glyph_error_o} !== 10'h0) begin n_fail++;
            $display("FAIL midrst_err: got %0h/%b/%b want 0/0/0", err_count_o, seq_error_o,
                     glyph_error_o); end
        vv0 = n_vv;
        send_digit(4'b1011, seg_of(4'h3), 8);
        n_vec++; if (n_vv - vv0 !== 0) begin n_fail++;
            $display("FAIL midrst_discard: got %0d want 0", n_vv - vv0); end
        send_digit(4'b0111, seg_of(4'h0), 8);
        n_vec++; if ({value_o, 8'(n_vv - vv0)} !== {8'h03, 8'd1}) begin n_fail++;
            $display("FAIL midrst_frame: got %0h/%0d want 03/1", value_o, n_vv - vv0); end
    endtask

    initial begin
        reset   = 1'b1;
        control = 4'hF;
        display = 8'h00;
        test_reset();
        test_basic();
        test_full_cycle();
        test_inject();
        test_glyph_error();
        test_filter();
        test_saturate_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
